// File: rtl/commit_trace_arbiter.sv
// commit_trace_arbiter: packs each cycle's retiring instructions plus an
// optional CSR write into one ordered, timestamped, sequence-numbered trace
// stream. The commit stage cannot stall. If a cycle's events do not all fit,
// the whole cycle is dropped and counted.
//
// Handshake: the head event moves on a rising edge where ev_valid=1 and
// ev_ready=1. ev_valid depends only on registered occupancy, never on the
// commit inputs. Head fields stay stable while ev_valid=1 and ev_ready=0.
module commit_trace_arbiter #(
  parameter int RETIRE_W = 3,
  parameter int ADDR_W   = 40,
  parameter int XLEN     = 64,
  parameter int DEPTH    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          trace_en,
  input  logic [RETIRE_W-1:0]           commit_valid,
  input  logic [RETIRE_W*ADDR_W-1:0]    commit_pc,
  input  logic [RETIRE_W*32-1:0]        commit_inst,
  input  logic [RETIRE_W*3-1:0]         commit_rtype,
  input  logic [RETIRE_W*5-1:0]         commit_ldst,
  input  logic [RETIRE_W*XLEN-1:0]      commit_wdata,
  input  logic                          csr_valid,
  input  logic [11:0]                   csr_addr,
  input  logic [XLEN-1:0]               csr_wdata,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic                          ev_kind,
  output logic [ADDR_W-1:0]             ev_pc,
  output logic [31:0]                   ev_inst,
  output logic [2:0]                    ev_rtype,
  output logic [11:0]                   ev_addr,
  output logic [XLEN-1:0]               ev_data,
  output logic [63:0]                   ev_cycle,
  output logic [31:0]                   ev_seq,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  input  logic                          clear_stats,
  output logic                          overflow,
  output logic [31:0]                   drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int N_W   = $clog2(RETIRE_W+2);

  // FIFO storage, one array per event field
  logic              mem_kind  [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [31:0]       mem_inst  [DEPTH];
  logic [2:0]        mem_rtype [DEPTH];
  logic [11:0]       mem_addr  [DEPTH];
  logic [XLEN-1:0]   mem_data  [DEPTH];
  logic [63:0]       mem_cycle [DEPTH];
  logic [31:0]       mem_seq   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [63:0]       cycle_cnt;
  logic [31:0]       seq_cnt;

  logic [PTR_W-1:0]  slot_off [RETIRE_W];
  logic [PTR_W-1:0]  slot_idx [RETIRE_W];
  logic [PTR_W-1:0]  csr_off;
  logic [PTR_W-1:0]  csr_idx;
  logic [N_W-1:0]    n_ev;
  logic [N_W-1:0]    enq_n;
  logic              deq;
  logic              accept;
  logic              drop;
  int                free_slots;
  logic [31:0]       drop_base;
  logic [32:0]       drop_sum;

  assign ev_valid = (count != '0);
  assign deq      = ev_valid & ev_ready;

  // Pack valid slots contiguously: each slot's offset is the number of valid
  // slots below it; the CSR event lands after all of them.
  always_comb begin
    int acc;
    acc = 0;
    for (int i = 0; i < RETIRE_W; i++) begin
      slot_off[i] = PTR_W'(acc);
      slot_idx[i] = wr_ptr + PTR_W'(acc);
      acc = acc + int'(commit_valid[i]);
    end
    csr_off = PTR_W'(acc);
    csr_idx = wr_ptr + PTR_W'(acc);
    n_ev    = N_W'(acc + int'(csr_valid));
  end

  // All-or-nothing admission; a dequeue in the same cycle frees one slot
  always_comb begin
    free_slots = DEPTH - int'(count) + int'(deq);
    accept     = trace_en && (n_ev != '0) && (int'(n_ev) <= free_slots);
    drop       = trace_en && (int'(n_ev) > free_slots);
    enq_n      = accept ? n_ev : '0;
    drop_base  = clear_stats ? 32'd0 : drop_cnt;
    drop_sum   = {1'b0, drop_base} + 33'(n_ev);
  end

  // Write accepted events into storage (contents need no reset: outputs are gated)
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < RETIRE_W; i++) begin
        if (commit_valid[i]) begin
          mem_kind[slot_idx[i]]  <= 1'b0;
          mem_pc[slot_idx[i]]    <= commit_pc[i*ADDR_W +: ADDR_W];
          mem_inst[slot_idx[i]]  <= commit_inst[i*32 +: 32];
          mem_rtype[slot_idx[i]] <= commit_rtype[i*3 +: 3];
          mem_addr[slot_idx[i]]  <= {7'd0, commit_ldst[i*5 +: 5]};
          mem_data[slot_idx[i]]  <= commit_wdata[i*XLEN +: XLEN];
          mem_cycle[slot_idx[i]] <= cycle_cnt;
          mem_seq[slot_idx[i]]   <= seq_cnt + 32'(slot_off[i]);
        end
      end
      if (csr_valid) begin
        mem_kind[csr_idx]  <= 1'b1;
        mem_pc[csr_idx]    <= '0;
        mem_inst[csr_idx]  <= '0;
        mem_rtype[csr_idx] <= '0;
        mem_addr[csr_idx]  <= csr_addr;
        mem_data[csr_idx]  <= csr_wdata;
        mem_cycle[csr_idx] <= cycle_cnt;
        mem_seq[csr_idx]   <= seq_cnt + 32'(csr_off);
      end
    end
  end

  // Pointers, occupancy, cycle/sequence counters and drop statistics
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
      seq_cnt   <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (accept) begin
        wr_ptr  <= wr_ptr + PTR_W'(n_ev);
        seq_cnt <= seq_cnt + 32'(n_ev);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq_n) - CNT_W'(deq);
      // a clear in the same cycle as a drop discards only the old total
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end else if (clear_stats) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  // Head fields come from the read pointer and read as zero when empty
  always_comb begin
    ev_kind  = 1'b0;
    ev_pc    = '0;
    ev_inst  = '0;
    ev_rtype = '0;
    ev_addr  = '0;
    ev_data  = '0;
    ev_cycle = '0;
    ev_seq   = '0;
    if (ev_valid) begin
      ev_kind  = mem_kind[rd_ptr];
      ev_pc    = mem_pc[rd_ptr];
      ev_inst  = mem_inst[rd_ptr];
      ev_rtype = mem_rtype[rd_ptr];
      ev_addr  = mem_addr[rd_ptr];
      ev_data  = mem_data[rd_ptr];
      ev_cycle = mem_cycle[rd_ptr];
      ev_seq   = mem_seq[rd_ptr];
    end
  end

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Testbench for commit_trace_arbiter: a directed opening sequence followed by
// randomized traffic. A reference model pushes expected events into a queue
// and a separate monitor compares the DUT head against it.
module tb_commit_trace_arbiter;

  localparam int RETIRE_W = 3;
  localparam int ADDR_W   = 40;
  localparam int XLEN     = 64;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int EW       = 1 + ADDR_W + 32 + 3 + 12 + XLEN + 64 + 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                       trace_en;
  logic [RETIRE_W-1:0]        commit_valid;
  logic [RETIRE_W*ADDR_W-1:0] commit_pc;
  logic [RETIRE_W*32-1:0]     commit_inst;
  logic [RETIRE_W*3-1:0]      commit_rtype;
  logic [RETIRE_W*5-1:0]      commit_ldst;
  logic [RETIRE_W*XLEN-1:0]   commit_wdata;
  logic                       csr_valid;
  logic [11:0]                csr_addr;
  logic [XLEN-1:0]            csr_wdata;
  logic                       ev_valid;
  logic                       ev_ready;
  logic                       ev_kind;
  logic [ADDR_W-1:0]          ev_pc;
  logic [31:0]                ev_inst;
  logic [2:0]                 ev_rtype;
  logic [11:0]                ev_addr;
  logic [XLEN-1:0]            ev_data;
  logic [63:0]                ev_cycle;
  logic [31:0]                ev_seq;
  logic [CNT_W-1:0]           count;
  logic                       clear_stats;
  logic                       overflow;
  logic [31:0]                drop_cnt;

  commit_trace_arbiter #(
    .RETIRE_W(RETIRE_W), .ADDR_W(ADDR_W), .XLEN(XLEN), .DEPTH(DEPTH)
  ) dut (
    .clock(clk), .reset(rst_n), .trace_en(trace_en),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rtype(commit_rtype), .commit_ldst(commit_ldst), .commit_wdata(commit_wdata),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_pc(ev_pc),
    .ev_inst(ev_inst), .ev_rtype(ev_rtype), .ev_addr(ev_addr), .ev_data(ev_data),
    .ev_cycle(ev_cycle), .ev_seq(ev_seq), .count(count), .clear_stats(clear_stats),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            started = 0;

  int            model_occ;
  longint        model_drop;
  bit            model_ovf;
  logic [63:0]   model_cycle;
  logic [31:0]   model_seq;
  int            m_n;
  int            m_free;
  bit            m_deq;

  function automatic logic [EW-1:0] pack_ev(input logic k, input logic [ADDR_W-1:0] pc,
                                            input logic [31:0] inst, input logic [2:0] rt,
                                            input logic [11:0] ad, input logic [XLEN-1:0] d,
                                            input logic [63:0] cy, input logic [31:0] sq);
    return {k, pc, inst, rt, ad, d, cy, sq};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ev(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sampled on the active edge) ----------------
  always @(posedge clk) begin
    if (!rst_n) begin
      model_occ   = 0;
      model_drop  = 0;
      model_ovf   = 0;
      model_cycle = '0;
      model_seq   = '0;
      exp_q.delete();
    end else begin
      m_n = $countones(commit_valid) + int'(csr_valid);
      m_deq = (model_occ > 0) && ev_ready;
      m_free = DEPTH - model_occ + int'(m_deq);
      if (clear_stats) begin
        model_drop = 0;
        model_ovf  = 0;
      end
      if (trace_en && m_n > 0) begin
        if (m_n <= m_free) begin
          for (int i = 0; i < RETIRE_W; i++) begin
            if (commit_valid[i]) begin
              exp_q.push_back(pack_ev(1'b0, commit_pc[i*ADDR_W +: ADDR_W],
                                      commit_inst[i*32 +: 32], commit_rtype[i*3 +: 3],
                                      {7'd0, commit_ldst[i*5 +: 5]},
                                      commit_wdata[i*XLEN +: XLEN], model_cycle, model_seq));
              model_seq = model_seq + 32'd1;
            end
          end
          if (csr_valid) begin
            exp_q.push_back(pack_ev(1'b1, '0, '0, '0, csr_addr, csr_wdata,
                                    model_cycle, model_seq));
            model_seq = model_seq + 32'd1;
          end
          model_occ = model_occ + m_n;
        end else begin
          model_ovf  = 1;
          model_drop = model_drop + m_n;
          if (model_drop > 64'hFFFF_FFFF) model_drop = 64'hFFFF_FFFF;
        end
      end
      model_occ   = model_occ - int'(m_deq);
      model_cycle = model_cycle + 64'd1;
    end
    started = 1;
  end

  // ---------------- monitor (samples on the opposite edge) ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("count", 64'(count), 64'(model_occ));
      chk("ev_valid", 64'(ev_valid), 64'(model_occ != 0));
      chk("overflow", 64'(overflow), 64'(model_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(model_drop));
      if (ev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL head_unexpected: got seq %0h expected no event", ev_seq);
        end else begin
          chk_ev("head_event",
                 pack_ev(ev_kind, ev_pc, ev_inst, ev_rtype, ev_addr, ev_data, ev_cycle, ev_seq),
                 exp_q[0]);
          if (ev_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk_ev("idle_zero",
               pack_ev(ev_kind, ev_pc, ev_inst, ev_rtype, ev_addr, ev_data, ev_cycle, ev_seq),
               '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    logic [63:0] r;
    for (int i = 0; i < RETIRE_W; i++) begin
      r = {$urandom(), $urandom()};
      commit_pc[i*ADDR_W +: ADDR_W] = r[ADDR_W-1:0];
      commit_inst[i*32 +: 32]       = $urandom();
      commit_rtype[i*3 +: 3]        = 3'($urandom_range(0, 7));
      commit_ldst[i*5 +: 5]         = 5'($urandom_range(0, 31));
      commit_wdata[i*XLEN +: XLEN]  = {$urandom(), $urandom()};
    end
    csr_addr  = 12'($urandom_range(0, 4095));
    csr_wdata = {$urandom(), $urandom()};
  endtask

  task automatic drive(input logic [RETIRE_W-1:0] v, input logic c, input logic t,
                       input logic r, input logic cl);
    commit_valid = v;
    csr_valid    = c;
    trace_en     = t;
    ev_ready     = r;
    clear_stats  = cl;
    rand_fields();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    trace_en = 1'b1;
    commit_valid = '0;
    csr_valid = 1'b0;
    ev_ready = 1'b0;
    clear_stats = 1'b0;
    commit_pc = '0;
    commit_inst = '0;
    commit_rtype = '0;
    commit_ldst = '0;
    commit_wdata = '0;
    csr_addr = '0;
    csr_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // three commits plus a CSR write in one cycle
    rand_fields();
    commit_valid = 3'b111;
    commit_pc[0*ADDR_W +: ADDR_W] = 40'h100;
    commit_pc[1*ADDR_W +: ADDR_W] = 40'h104;
    commit_pc[2*ADDR_W +: ADDR_W] = 40'h108;
    csr_valid = 1'b1;
    csr_addr  = 12'h300;
    csr_wdata = 64'h8;
    ev_ready  = 1'b1;
    tick();
    repeat (6) drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);

    // gap in the valid mask
    drive(3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);

    // fill to full under backpressure, then overflow a 3-event cycle
    repeat (DEPTH) drive(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
    // enqueue and dequeue together at full
    drive(3'b001, 1'b0, 1'b1, 1'b1, 1'b0);
    // down to 14, then a 3-event cycle is dropped and a 2-event cycle fits
    repeat (2) drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
    // clear together with a 2-event drop, then clear alone
    drive(3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    // tracing disabled with activity
    repeat (5) drive(3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    // reach seven entries, then reset mid-stream
    repeat (7) drive(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(3'b001, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);

    // randomized traffic with light, then heavy, backpressure
    for (int k = 0; k < 800; k++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      drive(3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) != 0),
            (k < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 29) == 0));
    end
    rst_n = 1'b1;

    // bounded drain
    for (int k = 0; k < 4 * DEPTH && model_occ != 0; k++) begin
      drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    drive(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("drain_queue_left", 64'(exp_q.size()), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_arbiter.md
# commit_trace_arbiter

Serialises per-cycle commit events into one ordered trace stream: up to RETIRE_W retiring instructions plus one CSR write. The stream is consumed one event per handshake by the cosim/tracer side. The block sits between the core commit stage and the trace consumer, and timestamps and sequence-numbers every event. The commit stage cannot be stalled, so overflow is handled by dropping whole cycles and counting the drops.

## Interface
- RETIRE_W, 3, commit slots per cycle
- ADDR_W, 40, PC width
- XLEN, 64, write-data width
- DEPTH, 16, FIFO entries; must be a power of 2 and at least RETIRE_W+1
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock
- trace_en  in  1  when 0, no events are enqueued and nothing is counted as dropped
- commit_valid  in  RETIRE_W  per-slot retire valid
- commit_pc  in  RETIRE_W*ADDR_W  slot i at bits [i*ADDR_W +: ADDR_W]
- commit_inst  in  RETIRE_W*32  instruction word per slot
- commit_rtype  in  RETIRE_W*3  destination type: 0 GPR, 1 FPR, 4 VR, other = none
- commit_ldst  in  RETIRE_W*5  logical destination register
- commit_wdata  in  RETIRE_W*XLEN  write data
- csr_valid  in  1  CSR write/set/clear occurred this cycle
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  final CSR value, already resolved for set/clear
- ev_valid  out  1  head event valid
- ev_ready  in  1  consumer accepts the head event
- ev_kind  out  1  0 instruction, 1 CSR
- ev_pc, ev_inst, ev_rtype  out  ADDR_W/32/3  head instruction fields; all 0 for CSR events
- ev_addr  out  12  ldst (zero-extended) for instruction events, csr_addr for CSR events
- ev_data  out  XLEN  wdata or csr_wdata
- ev_cycle  out  64  cycle stamp of the event
- ev_seq  out  32  event sequence number
- count  out  $clog2(DEPTH+1)  current occupancy
- clear_stats  in  1  clears overflow and drop_cnt
- overflow  out  1  sticky; set when any cycle's events were dropped
- drop_cnt  out  32  saturating count of dropped events

## Operation
- Cycle counter: 64-bit, 0 in reset, +1 every cycle afterwards. The first cycle after reset release stamps 0. Wraps modulo 2^64.
- Event count per cycle: n = popcount(commit_valid) + csr_valid, so 0..RETIRE_W+1.
- Enqueue order within a cycle:
  - valid commit slots in ascending index, packed contiguously (gaps in commit_valid are skipped);
  - the CSR event last.
- All events from one cycle share that cycle's ev_cycle stamp.
- Space rule: free = DEPTH - count + deq, where deq = ev_valid & ev_ready in the same cycle.
  - If trace_en=1 and n <= free: all n events are enqueued.
  - If trace_en=1 and n > free: none of the n events are enqueued. drop_cnt += n, saturating at 2^32-1, and overflow is set. Partial enqueue never occurs.
- Sequence numbers: a 32-bit counter, 0 in reset. Each enqueued event takes the current value, which then increments by 1 and wraps at 2^32. Dropped events consume no numbers, so a consumer sees gapless seq even under drops.
- clear_stats=1 zeroes overflow and drop_cnt at the next edge. If a drop happens in the same cycle, clear wins for the old value: the result is overflow=1 and drop_cnt=n.
- Storage: circular FIFO with wrapping read and write pointers. The write pointer advances by the enqueued count, modulo DEPTH.
- Head fields are driven from the FIFO entry at the read pointer. They hold stable while ev_valid=1 and ev_ready=0.
- Reset mid-stream discards all FIFO contents without emitting them.
- Reset values: ev_valid=0, count=0, overflow=0, drop_cnt=0, seq counter 0, cycle counter 0. All ev_* data outputs are 0 while ev_valid=0.

## Timing
- Events enqueued at edge k appear at the head no earlier than the cycle after edge k, i.e. ev_valid can first be 1 one cycle after the events were presented.
- Into an empty FIFO, the first event of the cycle is presented one cycle later, and subsequent events follow one per accepted handshake.
- Throughput: one event per cycle while ev_ready=1.
- count updates at each edge by +enqueued - deq.
- Simultaneous enqueue and dequeue at full (count=DEPTH) gives free=1. In that case a cycle with n=1 is accepted.
- ev_valid = (count != 0) and is never combinationally dependent on commit inputs.

## Test plan
- Reset, then 3 commits in one cycle with PCs 0x100/0x104/0x108 plus a CSR write 0x300 <- 0x8; ev_ready=1 -> 4 events on consecutive cycles with seq 0..3, kinds 0,0,0,1, identical ev_cycle, first event valid one cycle after input.
- commit_valid=3'b101 -> exactly 2 instruction events, slot0 then slot2, seq contiguous.
- Hold ev_ready=0 and fill to DEPTH=16 with 1 event/cycle; then present n=3 -> count stays 16, drop_cnt=3, overflow=1, head fields unchanged. Next, ev_ready=1 with n=1 -> accepted, count stays 16, seq continues without gap.
- count=14, no dequeue, n=3 -> whole cycle dropped (none enqueued); n=2 next cycle -> both enqueued, count=16.
- Assert clear_stats together with a 2-event drop -> overflow=1, drop_cnt=2; then clear_stats alone -> both 0.
- trace_en=0 with activity for 5 cycles -> no events, drop_cnt unchanged. Drive reset low mid-stream with count=7 -> next cycle count=0, ev_valid=0, next enqueued event has seq 0 and ev_cycle counted from 0.
